// File: rtl/ring_osc_freq_meter.sv
// ring_osc_freq_meter
//   Gated frequency counter for a tapped ring oscillator. On an accepted start
//   it selects the ring tap and enables the ring. It waits SETTLE_CYCLES for the
//   ring to settle, then counts synchronised osc_in rising edges for gate_len
//   clk cycles. It then disables the ring and reports a registered count.
// Ports
//   clk        system clock
//   rst_n      synchronous reset, active low
//   osc_in     ring oscillator output (asynchronous to clk)
//   start      measurement request, sampled only while idle
//   tap_sel    ring tap select, captured on accepted start
//   gate_len   window length in clk cycles, captured on accepted start
//   osc_en     ring oscillator enable (high in SETTLE and GATE)
//   tap_out    registered tap select driven to the ring
//   busy       high from accepted start through DONE
//   done       one-cycle pulse, count_out/overflow valid
//   count_out  edges counted in the last window
//   overflow   count saturated in the last window
module ring_osc_freq_meter #(
    parameter int SETTLE_CYCLES = 8,
    parameter int GATE_W        = 16,
    parameter int CNT_W         = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              osc_in,
    input  logic              start,
    input  logic [2:0]        tap_sel,
    input  logic [GATE_W-1:0] gate_len,
    output logic              osc_en,
    output logic [2:0]        tap_out,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count_out,
    output logic              overflow
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETTLE, GATE, DONE} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   rise;
    logic [SW-1:0]          settle_cnt;
    logic [GATE_W-1:0]      gate_cnt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   ovf, ovf_nxt;

    // Edge detect on the last synchroniser stage against a one-flop history.
    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

    always_comb begin
        state_nxt = state;
        osc_en    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = (gate_len == '0) ? DONE : SETTLE;
            end
            SETTLE: begin
                osc_en = 1'b1;
                if (settle_cnt == '0) state_nxt = GATE;
            end
            GATE: begin
                osc_en = 1'b1;
                if (gate_cnt == GATE_W'(1)) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Saturating edge counter; overflow marks an edge lost at all-ones.
    always_comb begin
        cnt_nxt = cnt;
        ovf_nxt = ovf;
        if (state == GATE && rise) begin
            if (&cnt) ovf_nxt = 1'b1;
            else      cnt_nxt = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sync_q     <= '0;
            hist_q     <= 1'b0;
            tap_out    <= '0;
            settle_cnt <= '0;
            gate_cnt   <= '0;
            cnt        <= '0;
            ovf        <= 1'b0;
            count_out  <= '0;
            overflow   <= 1'b0;
        end else begin
            state  <= state_nxt;
            sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
            hist_q <= sync_q[SYNC_STAGES-1];
            case (state)
                IDLE: if (start) begin
                    tap_out    <= tap_sel;
                    gate_cnt   <= gate_len;
                    settle_cnt <= SW'(SETTLE_CYCLES - 1);
                    cnt        <= '0;
                    ovf        <= 1'b0;
                    count_out  <= '0;
                    overflow   <= 1'b0;
                end
                SETTLE: settle_cnt <= settle_cnt - 1'b1;
                GATE: begin
                    cnt      <= cnt_nxt;
                    ovf      <= ovf_nxt;
                    gate_cnt <= gate_cnt - 1'b1;
                    // Result registered on entry to DONE, including the final cycle's edge.
                    if (gate_cnt == GATE_W'(1)) begin
                        count_out <= cnt_nxt;
                        overflow  <= ovf_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
module tb_ring_osc_freq_meter;

    localparam int GATE_W = 16;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              osc_in;
    logic              start;
    logic [2:0]        tap_sel;
    logic [GATE_W-1:0] gate_len;
    logic              osc_en;
    logic [2:0]        tap_out;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count_out;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    // 0: osc_in low, 1: period 4 clk (2 high / 2 low), 2: toggle every clk
    int osc_mode = 0;
    int osc_ph   = 0;

    ring_osc_freq_meter #(
        .SETTLE_CYCLES(8), .GATE_W(GATE_W), .CNT_W(CNT_W), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .start(start),
        .tap_sel(tap_sel), .gate_len(gate_len), .osc_en(osc_en),
        .tap_out(tap_out), .busy(busy), .done(done),
        .count_out(count_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        osc_ph <= osc_ph + 1;
        case (osc_mode)
            1:       osc_in <= osc_ph[1];
            2:       osc_in <= osc_ph[0];
            default: osc_in <= 1'b0;
        endcase
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one start, then watch the run. lat = edges after the accepting edge
    // until done is seen (-1 on timeout). mid > 0 pulses a second start at that
    // sampled cycle with gate_len=3 and tap_sel=7.
    task automatic run_meas(input logic [2:0] tap, input int len, input int mid,
                            output int lat, output int en_cyc, output int dones,
                            output int tap_bad);
        int n;
        lat = -1; en_cyc = 0; dones = 0; tap_bad = 0;
        tap_sel  = tap;
        gate_len = GATE_W'(len);
        start    = 1'b1;
        step();
        start = 1'b0;
        for (n = 1; n < 3000; n++) begin
            if (osc_en) en_cyc++;
            if (tap_out !== tap) tap_bad++;
            if (done) begin
                dones++;
                lat = n - 1;
                break;
            end
            if (n == mid) begin
                start = 1'b1; gate_len = GATE_W'(3); tap_sel = 3'd7;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (done) dones++;
            if (osc_en) en_cyc++;
        end
    endtask

    int lat, en_cyc, dones, tap_bad;

    initial begin
        rst_n = 1'b0; start = 1'b0; tap_sel = '0; gate_len = '0; osc_in = 1'b0;
        step(); step();
        chk("rst_osc_en", osc_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count_out, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_tap", tap_out, 0);
        rst_n = 1'b1;
        step();

        // 1: silent ring, 50-cycle window
        osc_mode = 0;
        run_meas(3'd1, 50, 0, lat, en_cyc, dones, tap_bad);
        chk("t1_latency", lat, 58);
        chk("t1_count", count_out, 0);
        chk("t1_ovf", overflow, 0);
        chk("t1_osc_en_cycles", en_cyc, 58);
        chk("t1_done_pulses", dones, 1);
        chk("t1_busy_after", busy, 0);

        // 2: period-4 ring, 100-cycle window, tap 5
        osc_mode = 1;
        run_meas(3'd5, 100, 0, lat, en_cyc, dones, tap_bad);
        chk("t2_latency", lat, 108);
        chk("t2_count", count_out, 25);
        chk("t2_ovf", overflow, 0);
        chk("t2_tap_bad", tap_bad, 0);
        chk("t2_tap_out", tap_out, 5);
        chk("t2_count_held", count_out, 25);

        // 3: zero-length window
        run_meas(3'd2, 0, 0, lat, en_cyc, dones, tap_bad);
        chk("t3_latency", lat, 0);
        chk("t3_count", count_out, 0);
        chk("t3_osc_en_cycles", en_cyc, 0);
        chk("t3_done_pulses", dones, 1);

        // 4: ring toggling every clk, 500 edges into an 8-bit counter
        osc_mode = 2;
        run_meas(3'd4, 1000, 0, lat, en_cyc, dones, tap_bad);
        chk("t4_latency", lat, 1008);
        chk("t4_count", count_out, 255);
        chk("t4_ovf", overflow, 1);

        // 5: start pulsed mid-GATE is ignored
        osc_mode = 1;
        run_meas(3'd2, 20, 15, lat, en_cyc, dones, tap_bad);
        chk("t5_latency", lat, 28);
        chk("t5_count", count_out, 5);
        chk("t5_ovf", overflow, 0);
        chk("t5_done_pulses", dones, 1);
        chk("t5_tap_bad", tap_bad, 0);

        // 6: reset for one cycle mid-GATE aborts without done
        tap_sel = 3'd6; gate_len = GATE_W'(100); start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 20; k++) step();
        chk("t6_pre_osc_en", osc_en, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6_osc_en", osc_en, 0);
        chk("t6_busy", busy, 0);
        chk("t6_count", count_out, 0);
        chk("t6_tap", tap_out, 0);
        dones = 0;
        for (int k = 0; k < 120; k++) begin
            if (done) dones++;
            step();
        end
        chk("t6_no_done", dones, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
